mem_issue_queue: RTL and testbench
==================================

# mem_issue_queue

In-order scheduler feeding the single-port memory pipeline. Buffers dispatched load/store micro-ops in a circular FIFO and issues them strictly in program order, one per cycle. Loads issue as soon as they reach the queue head. Stores are held at the head until the ROB reports that store's entry as the commit head. The block sits between dispatch/register-read and the memory pipeline, which never stalls.

## Interface
- DEPTH, 8: queue entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH): pointer width; derived, not overridden.
- Physical-register width is `PR_ADDR_W from the shared defines header.

- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- flush  in  1  discard all queued entries (mispredict/exception).
- enq_valid  in  1  dispatch presents a memory op.
- enq_ready  out  1  queue can accept; equals !full.
- enq_opcode  in  4  op; bit0=1 store, 0 load.
- enq_rob_entry  in  5  ROB tag.
- enq_base_val  in  16  base address operand.
- enq_offset  in  8  offset operand.
- enq_dest_reg  in  `PR_ADDR_W  load destination physical register.
- enq_data  in  8  store data.
- enq_imm  in  4  addressing flags; bit3 = zero-page wrap.
- enq_dest_arch_regs  in  8  architectural destination mask.
- rob_head_entry  in  5  ROB tag currently at commit.
- rob_head_valid  in  1  rob_head_entry is meaningful.
- issue_valid  out  1  head entry is eligible to issue.
- issue_ready  in  1  memory pipeline accepts; tied high today, honoured anyway.
- issue_opcode, issue_rob_entry, issue_base_val, issue_offset, issue_dest_reg, issue_data, issue_imm, issue_dest_arch_regs  out  (as enq_*)  head entry fields.
- count  out  PTR_W+1  occupied entries.
- store_wait  out  1  head is a store blocked on commit.

## Operation
- Storage: DEPTH-entry array, head/tail pointers PTR_W bits wide with natural wrap, plus separate count register. full = (count==DEPTH); empty = (count==0).
- Enqueue fires when enq_valid && enq_ready. The entry is written at tail, then tail increments.
- Eligibility:
  - Load at head: eligible when !empty.
  - Store at head: eligible when !empty && rob_head_valid && rob_head_entry==head.rob_entry.
- issue_valid = eligible && !flush.
- Dequeue fires when issue_valid && issue_ready; head then increments.
- Younger entries never bypass the head. This preserves memory ordering without address disambiguation.
- count update:
  - enqueue only: +1.
  - dequeue only: -1.
  - both in the same cycle: unchanged.
- enq_ready ignores a same-cycle dequeue. When full, enqueue is refused even if the head issues that cycle.
- flush: head, tail and count go to 0 at the next edge. Enqueue and dequeue in that cycle are discarded. flush takes priority over everything except rst.
- Outputs are combinational reads of the head entry. When issue_valid=0, field values are don't-care.
- store_wait = !empty && head.opcode[0] && !eligible.

## Timing
- Reset (rst sampled high at posedge):
  - head, tail and count cleared to 0.
  - issue_valid=0, store_wait=0, enq_ready=1.
  - Entry array is not cleared.
- Enqueue latency: an op accepted at edge N is visible at head by cycle N+1 if the queue was empty. Earliest issue is therefore the cycle after acceptance; there is no same-cycle bypass.
- Throughput: one enqueue and one issue per cycle sustained.
- ROB match is evaluated combinationally each cycle. A store issues in the same cycle its tag appears at rob_head.
- rst mid-operation behaves identically to flush, plus outputs are forced to reset values.

## Structure
- Shared package/defines: `PR_ADDR_W, the opcode store-bit index, and the ROB tag width (5).
- One natural sub-module: mem_iq_storage, a parameterised register array with one write port and one read port.
- Pointer, count and eligibility logic stay in the top module.

## Test plan
- Reset, then enqueue loads tagged 3, 4, 5 on consecutive cycles with issue_ready=1 → issue_valid high from cycle 2 to cycle 4; tags out in order 3, 4, 5; count peaks at 1.
- Enqueue store tag 7 with rob_head_entry=6 → issue_valid=0 and store_wait=1. Set rob_head_entry=7 → issue fires that cycle; count returns to 0.
- Store tag 9 blocked at head, load tag 10 behind it → load does not issue until the store issues; issue order is 9 then 10.
- Fill all 8 entries → enq_ready=0, count=8. Then enqueue+issue in the same cycle while full → enqueue refused, count=7. Then wrap the tail past index 7 → FIFO order is preserved.
- With 5 entries queued, assert flush while enq_valid=1 → next cycle count=0, issue_valid=0, and the new op is dropped.
- Assert rst while 3 entries are queued and a store is waiting → next cycle count=0, store_wait=0, enq_ready=1.

Source files
------------

// File: rtl/mem_issue_queue_pkg.sv
// Shared types and widths for the in-order memory issue queue.
// Entry payload layout is fixed here so storage and top agree on packing.
package mem_issue_queue_pkg;

    localparam int unsigned PR_ADDR_W   = 7;
    localparam int unsigned ROB_TAG_W   = 5;
    localparam int unsigned OPCODE_W    = 4;
    localparam int unsigned BASE_W      = 16;
    localparam int unsigned OFFSET_W    = 8;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned IMM_W       = 4;
    localparam int unsigned ARCH_MASK_W = 8;
    localparam int unsigned STORE_BIT   = 0;

    typedef struct packed {
        logic [OPCODE_W-1:0]    opcode;
        logic [ROB_TAG_W-1:0]   rob_entry;
        logic [BASE_W-1:0]      base_val;
        logic [OFFSET_W-1:0]    offset;
        logic [PR_ADDR_W-1:0]   dest_reg;
        logic [DATA_W-1:0]      data;
        logic [IMM_W-1:0]       imm;
        logic [ARCH_MASK_W-1:0] dest_arch_regs;
    } iq_entry_t;

    localparam int unsigned ENTRY_W = $bits(iq_entry_t);

endpackage

// File: rtl/mem_iq_storage.sv
// Register array with one synchronous write port and one combinational read port.
// Contents are intentionally not reset; validity is tracked by the owner's pointers.
module mem_iq_storage #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [W-1:0]  i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [W-1:0]  o_rd_data
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/mem_issue_queue.sv
// In-order load/store issue queue: circular FIFO whose head issues one op per cycle,
// holding stores at the head until the ROB presents the same tag at commit.
module mem_issue_queue
    import mem_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,

    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  logic [OPCODE_W-1:0]    enq_opcode,
    input  logic [ROB_TAG_W-1:0]   enq_rob_entry,
    input  logic [BASE_W-1:0]      enq_base_val,
    input  logic [OFFSET_W-1:0]    enq_offset,
    input  logic [PR_ADDR_W-1:0]   enq_dest_reg,
    input  logic [DATA_W-1:0]      enq_data,
    input  logic [IMM_W-1:0]       enq_imm,
    input  logic [ARCH_MASK_W-1:0] enq_dest_arch_regs,

    input  logic [ROB_TAG_W-1:0]   rob_head_entry,
    input  logic                   rob_head_valid,

    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [OPCODE_W-1:0]    issue_opcode,
    output logic [ROB_TAG_W-1:0]   issue_rob_entry,
    output logic [BASE_W-1:0]      issue_base_val,
    output logic [OFFSET_W-1:0]    issue_offset,
    output logic [PR_ADDR_W-1:0]   issue_dest_reg,
    output logic [DATA_W-1:0]      issue_data,
    output logic [IMM_W-1:0]       issue_imm,
    output logic [ARCH_MASK_W-1:0] issue_dest_arch_regs,

    output logic [PTR_W:0]         count,
    output logic                   store_wait
);

    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    iq_entry_t        w_enq_entry;
    iq_entry_t        w_head_entry;
    logic [ENTRY_W-1:0] w_rd_bits;
    logic             w_empty;
    logic             w_full;
    logic             w_is_store;
    logic             w_rob_match;
    logic             w_eligible;
    logic             w_enq;
    logic             w_deq;

    always_comb begin
        w_enq_entry                = '0;
        w_enq_entry.opcode         = enq_opcode;
        w_enq_entry.rob_entry      = enq_rob_entry;
        w_enq_entry.base_val       = enq_base_val;
        w_enq_entry.offset         = enq_offset;
        w_enq_entry.dest_reg       = enq_dest_reg;
        w_enq_entry.data           = enq_data;
        w_enq_entry.imm            = enq_imm;
        w_enq_entry.dest_arch_regs = enq_dest_arch_regs;
    end

    // Writes are suppressed while the queue is being cleared so stale slots stay untouched.
    mem_iq_storage #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_storage (
        .clk       (clk),
        .i_wr_en   (w_enq && !flush && !rst),
        .i_wr_addr (r_tail),
        .i_wr_data (w_enq_entry),
        .i_rd_addr (r_head),
        .o_rd_data (w_rd_bits)
    );

    assign w_head_entry = iq_entry_t'(w_rd_bits);

    assign w_empty     = (r_count == CNT_W'(0));
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_is_store  = w_head_entry.opcode[STORE_BIT];
    assign w_rob_match = rob_head_valid && (rob_head_entry == w_head_entry.rob_entry);
    assign w_eligible  = !w_empty && (!w_is_store || w_rob_match);

    assign enq_ready   = !w_full;
    assign issue_valid = w_eligible && !flush && !rst;
    assign store_wait  = !rst && !w_empty && w_is_store && !w_eligible;
    assign count       = r_count;

    // enq_ready deliberately ignores a same-cycle dequeue to keep the ready path short.
    assign w_enq = enq_valid && enq_ready;
    assign w_deq = issue_valid && issue_ready;

    assign issue_opcode         = w_head_entry.opcode;
    assign issue_rob_entry      = w_head_entry.rob_entry;
    assign issue_base_val       = w_head_entry.base_val;
    assign issue_offset         = w_head_entry.offset;
    assign issue_dest_reg       = w_head_entry.dest_reg;
    assign issue_data           = w_head_entry.data;
    assign issue_imm            = w_head_entry.imm;
    assign issue_dest_arch_regs = w_head_entry.dest_arch_regs;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_deq) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed self-checking bench for mem_issue_queue: ordering, store hold,
// full/wrap behaviour, flush and reset.
module tb_mem_issue_queue;
    import mem_issue_queue_pkg::*;

    logic                   clk;
    logic                   rst;
    logic                   flush;
    logic                   enq_valid;
    logic                   enq_ready;
    logic [OPCODE_W-1:0]    enq_opcode;
    logic [ROB_TAG_W-1:0]   enq_rob_entry;
    logic [BASE_W-1:0]      enq_base_val;
    logic [OFFSET_W-1:0]    enq_offset;
    logic [PR_ADDR_W-1:0]   enq_dest_reg;
    logic [DATA_W-1:0]      enq_data;
    logic [IMM_W-1:0]       enq_imm;
    logic [ARCH_MASK_W-1:0] enq_dest_arch_regs;
    logic [ROB_TAG_W-1:0]   rob_head_entry;
    logic                   rob_head_valid;
    logic                   issue_valid;
    logic                   issue_ready;
    logic [OPCODE_W-1:0]    issue_opcode;
    logic [ROB_TAG_W-1:0]   issue_rob_entry;
    logic [BASE_W-1:0]      issue_base_val;
    logic [OFFSET_W-1:0]    issue_offset;
    logic [PR_ADDR_W-1:0]   issue_dest_reg;
    logic [DATA_W-1:0]      issue_data;
    logic [IMM_W-1:0]       issue_imm;
    logic [ARCH_MASK_W-1:0] issue_dest_arch_regs;
    logic [3:0]             count;
    logic                   store_wait;

    int errors = 0;
    int checks = 0;

    mem_issue_queue #(.DEPTH(8)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush                (flush),
        .enq_valid            (enq_valid),
        .enq_ready            (enq_ready),
        .enq_opcode           (enq_opcode),
        .enq_rob_entry        (enq_rob_entry),
        .enq_base_val         (enq_base_val),
        .enq_offset           (enq_offset),
        .enq_dest_reg         (enq_dest_reg),
        .enq_data             (enq_data),
        .enq_imm              (enq_imm),
        .enq_dest_arch_regs   (enq_dest_arch_regs),
        .rob_head_entry       (rob_head_entry),
        .rob_head_valid       (rob_head_valid),
        .issue_valid          (issue_valid),
        .issue_ready          (issue_ready),
        .issue_opcode         (issue_opcode),
        .issue_rob_entry      (issue_rob_entry),
        .issue_base_val       (issue_base_val),
        .issue_offset         (issue_offset),
        .issue_dest_reg       (issue_dest_reg),
        .issue_data           (issue_data),
        .issue_imm            (issue_imm),
        .issue_dest_arch_regs (issue_dest_arch_regs),
        .count                (count),
        .store_wait           (store_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every field is derived from the tag so the bench can predict it independently.
    task automatic enq_drive(input logic v, input logic st, input logic [4:0] tag);
        enq_valid          = v;
        enq_opcode         = st ? 4'b0001 : 4'b0010;
        enq_rob_entry      = tag;
        enq_base_val       = 16'h1000 + 16'(tag);
        enq_offset         = 8'(tag) + 8'h40;
        enq_dest_reg       = PR_ADDR_W'(tag);
        enq_data           = 8'(tag) ^ 8'hA5;
        enq_imm            = 4'h8;
        enq_dest_arch_regs = 8'h01 << tag[2:0];
    endtask

    initial begin
        logic [4:0] exp_tags [8];

        rst = 1'b1; flush = 1'b0; issue_ready = 1'b1;
        rob_head_valid = 1'b0; rob_head_entry = 5'd0;
        enq_drive(1'b0, 1'b0, 5'd0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_issue_valid", 32'(issue_valid), 0);
        chk("rst_store_wait", 32'(store_wait), 0);
        chk("rst_enq_ready", 32'(enq_ready), 1);

        // Three back-to-back loads flow straight through.
        enq_drive(1'b1, 1'b0, 5'd3);
        #1;
        chk("ld_empty_no_issue", 32'(issue_valid), 0);
        tick();
        enq_drive(1'b1, 1'b0, 5'd4);
        #1;
        chk("ld3_valid", 32'(issue_valid), 1);
        chk("ld3_tag", 32'(issue_rob_entry), 3);
        chk("ld3_base", 32'(issue_base_val), 32'h1003);
        chk("ld3_offset", 32'(issue_offset), 32'h43);
        chk("ld3_data", 32'(issue_data), 32'hA6);
        chk("ld3_dest", 32'(issue_dest_reg), 3);
        chk("ld3_arch", 32'(issue_dest_arch_regs), 32'h08);
        chk("ld3_count", 32'(count), 1);
        tick();
        enq_drive(1'b1, 1'b0, 5'd5);
        #1;
        chk("ld4_tag", 32'(issue_rob_entry), 4);
        chk("ld4_count", 32'(count), 1);
        tick();
        enq_drive(1'b0, 1'b0, 5'd0);
        #1;
        chk("ld5_valid", 32'(issue_valid), 1);
        chk("ld5_tag", 32'(issue_rob_entry), 5);
        tick();
        chk("ld_drain_count", 32'(count), 0);
        chk("ld_drain_valid", 32'(issue_valid), 0);

        // Store waits for its ROB tag, then issues in the matching cycle.
        rob_head_valid = 1'b1; rob_head_entry = 5'd6;
        enq_drive(1'b1, 1'b1, 5'd7);
        tick();
        enq_drive(1'b0, 1'b0, 5'd0);
        #1;
        chk("st7_blocked_valid", 32'(issue_valid), 0);
        chk("st7_store_wait", 32'(store_wait), 1);
        chk("st7_count", 32'(count), 1);
        rob_head_entry = 5'd7;
        #1;
        chk("st7_match_valid", 32'(issue_valid), 1);
        chk("st7_match_wait", 32'(store_wait), 0);
        chk("st7_tag", 32'(issue_rob_entry), 7);
        tick();
        chk("st7_count_after", 32'(count), 0);

        // A blocked store holds back the younger load.
        rob_head_entry = 5'd8;
        enq_drive(1'b1, 1'b1, 5'd9);
        tick();
        enq_drive(1'b1, 1'b0, 5'd10);
        tick();
        enq_drive(1'b0, 1'b0, 5'd0);
        #1;
        chk("st9_blocked", 32'(issue_valid), 0);
        chk("st9_count", 32'(count), 2);
        chk("st9_head", 32'(issue_rob_entry), 9);
        tick();
        chk("st9_still_count", 32'(count), 2);
        rob_head_entry = 5'd9;
        #1;
        chk("st9_issue", 32'(issue_valid), 1);
        chk("st9_issue_tag", 32'(issue_rob_entry), 9);
        tick();
        chk("ld10_valid", 32'(issue_valid), 1);
        chk("ld10_tag", 32'(issue_rob_entry), 10);
        chk("ld10_count", 32'(count), 1);
        tick();
        chk("st9_drain_count", 32'(count), 0);

        // Fill to full, refuse enqueue while issuing, then drain across the wrap.
        rob_head_valid = 1'b0;
        issue_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            enq_drive(1'b1, 1'b0, 5'(16 + i));
            tick();
        end
        enq_drive(1'b0, 1'b0, 5'd0);
        #1;
        chk("full_enq_ready", 32'(enq_ready), 0);
        chk("full_count", 32'(count), 8);
        enq_drive(1'b1, 1'b0, 5'd24);
        issue_ready = 1'b1;
        #1;
        chk("full_issue_valid", 32'(issue_valid), 1);
        chk("full_issue_tag", 32'(issue_rob_entry), 16);
        tick();
        chk("full_refused_count", 32'(count), 7);
        issue_ready = 1'b0;
        enq_drive(1'b1, 1'b0, 5'd25);
        tick();
        enq_drive(1'b0, 1'b0, 5'd0);
        chk("refill_count", 32'(count), 8);
        exp_tags = '{5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd25};
        issue_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("wrap_valid_%0d", i), 32'(issue_valid), 1);
            chk($sformatf("wrap_tag_%0d", i), 32'(issue_rob_entry), 32'(exp_tags[i]));
            tick();
        end
        chk("wrap_drain_count", 32'(count), 0);

        // Flush with an enqueue pending drops everything, including the new op.
        issue_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            enq_drive(1'b1, 1'b0, 5'(i));
            tick();
        end
        chk("pre_flush_count", 32'(count), 5);
        flush = 1'b1;
        enq_drive(1'b1, 1'b0, 5'd30);
        #1;
        chk("flush_gate_valid", 32'(issue_valid), 0);
        tick();
        flush = 1'b0;
        enq_drive(1'b0, 1'b0, 5'd0);
        #1;
        chk("flush_count", 32'(count), 0);
        chk("flush_issue_valid", 32'(issue_valid), 0);
        tick();
        chk("flush_dropped_count", 32'(count), 0);
        enq_drive(1'b1, 1'b0, 5'd11);
        tick();
        enq_drive(1'b0, 1'b0, 5'd0);
        #1;
        chk("post_flush_tag", 32'(issue_rob_entry), 11);
        chk("post_flush_count", 32'(count), 1);
        issue_ready = 1'b1;
        tick();
        chk("post_flush_drain", 32'(count), 0);

        // Reset mid-operation with a waiting store.
        rob_head_valid = 1'b1; rob_head_entry = 5'd0;
        enq_drive(1'b1, 1'b1, 5'd12);
        tick();
        enq_drive(1'b1, 1'b0, 5'd13);
        tick();
        enq_drive(1'b1, 1'b0, 5'd14);
        tick();
        enq_drive(1'b0, 1'b0, 5'd0);
        #1;
        chk("pre_rst_count", 32'(count), 3);
        chk("pre_rst_store_wait", 32'(store_wait), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_store_wait", 32'(store_wait), 0);
        chk("mid_rst_enq_ready", 32'(enq_ready), 1);
        chk("mid_rst_issue_valid", 32'(issue_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
